// File: rtl/rx_sample_window_buffer.sv
// rx_sample_window_buffer: circular 20-entry store of filtered rx samples that
// feeds rx_correlation_unit. Samples are written in place at wr_ptr; the
// correlator uses oorder_pointer to find the oldest sample.
// Optional feature: define RX_SWB_DECIM_EN to accept only every DECIM-th
// valid sample (phase counter); undefined, every valid sample is accepted.
module rx_sample_window_buffer #(
  parameter int SAMPLE_W = 16,
  parameter int DEPTH    = 20,
  parameter int DECIM    = 4
) (
  input  logic                crx_clk,
  input  logic                rrx_rst,
  input  logic                erx_en,
  input  logic [SAMPLE_W-1:0] idata_in,
  input  logic                idata_valid,
  input  logic                iflush,
  output logic [SAMPLE_W-1:0] odata_sample_0,
  output logic [SAMPLE_W-1:0] odata_sample_1,
  output logic [SAMPLE_W-1:0] odata_sample_2,
  output logic [SAMPLE_W-1:0] odata_sample_3,
  output logic [SAMPLE_W-1:0] odata_sample_4,
  output logic [SAMPLE_W-1:0] odata_sample_5,
  output logic [SAMPLE_W-1:0] odata_sample_6,
  output logic [SAMPLE_W-1:0] odata_sample_7,
  output logic [SAMPLE_W-1:0] odata_sample_8,
  output logic [SAMPLE_W-1:0] odata_sample_9,
  output logic [SAMPLE_W-1:0] odata_sample_10,
  output logic [SAMPLE_W-1:0] odata_sample_11,
  output logic [SAMPLE_W-1:0] odata_sample_12,
  output logic [SAMPLE_W-1:0] odata_sample_13,
  output logic [SAMPLE_W-1:0] odata_sample_14,
  output logic [SAMPLE_W-1:0] odata_sample_15,
  output logic [SAMPLE_W-1:0] odata_sample_16,
  output logic [SAMPLE_W-1:0] odata_sample_17,
  output logic [SAMPLE_W-1:0] odata_sample_18,
  output logic [SAMPLE_W-1:0] odata_sample_19,
  output logic [4:0]          oorder_pointer,
  output logic                onew_sample_trig,
  output logic [4:0]          ofill_level,
  output logic                oprimed
);

  localparam logic [4:0] LAST_IDX = 5'(DEPTH - 1);
  localparam logic [4:0] FULL_CNT = 5'(DEPTH);

  logic [SAMPLE_W-1:0] slot_q [DEPTH];
  logic [SAMPLE_W-1:0] slot_d [DEPTH];
  logic [4:0]          wr_ptr_q, wr_ptr_d;
  logic [4:0]          fill_q,   fill_d;
  logic                primed_q, primed_d;
  logic                trig_q,   trig_d;
  logic                flush;
  logic                accept;

  assign flush = erx_en & iflush;

`ifdef RX_SWB_DECIM_EN
  logic [3:0] phase_q, phase_d;

  // Decimation phase: advances on every enabled valid, wraps at DECIM-1.
  always_comb begin
    phase_d = phase_q;
    if (flush) begin
      phase_d = '0;
    end else if (erx_en && idata_valid) begin
      phase_d = (phase_q == 4'(DECIM - 1)) ? '0 : phase_q + 4'd1;
    end
  end

  // Phase register.
  always_ff @(posedge crx_clk or posedge rrx_rst) begin
    if (rrx_rst) phase_q <= '0;
    else         phase_q <= phase_d;
  end

  assign accept = erx_en & idata_valid & ~iflush & (phase_q == 4'd0);
`else
  logic unused_decim;
  assign unused_decim = ^4'(DECIM);
  assign accept = erx_en & idata_valid & ~iflush;
`endif

  // Next-state for slots, pointer, fill, primed and trigger.
  always_comb begin
    for (int unsigned i = 0; i < DEPTH; i++) slot_d[i] = slot_q[i];
    wr_ptr_d = wr_ptr_q;
    fill_d   = fill_q;
    primed_d = primed_q;
    trig_d   = 1'b0;
    if (flush) begin
      for (int unsigned i = 0; i < DEPTH; i++) slot_d[i] = '0;
      wr_ptr_d = '0;
      fill_d   = '0;
      primed_d = 1'b0;
    end else if (accept) begin
      slot_d[wr_ptr_q] = idata_in;
      wr_ptr_d = (wr_ptr_q == LAST_IDX) ? '0 : wr_ptr_q + 5'd1;
      fill_d   = (fill_q == FULL_CNT) ? fill_q : fill_q + 5'd1;
      primed_d = primed_q | (fill_d == FULL_CNT);
      // Trigger is registered alongside the write so data, pointer and pulse
      // become visible in the same cycle.
      trig_d   = (fill_d == FULL_CNT);
    end
  end

  // State registers with asynchronous clear.
  always_ff @(posedge crx_clk or posedge rrx_rst) begin
    if (rrx_rst) begin
      for (int unsigned i = 0; i < DEPTH; i++) slot_q[i] <= '0;
      wr_ptr_q <= '0;
      fill_q   <= '0;
      primed_q <= 1'b0;
      trig_q   <= 1'b0;
    end else begin
      for (int unsigned i = 0; i < DEPTH; i++) slot_q[i] <= slot_d[i];
      wr_ptr_q <= wr_ptr_d;
      fill_q   <= fill_d;
      primed_q <= primed_d;
      trig_q   <= trig_d;
    end
  end

  assign oorder_pointer   = wr_ptr_q;
  assign ofill_level      = fill_q;
  assign oprimed          = primed_q;
  assign onew_sample_trig = trig_q;

  assign odata_sample_0  = slot_q[0];
  assign odata_sample_1  = slot_q[1];
  assign odata_sample_2  = slot_q[2];
  assign odata_sample_3  = slot_q[3];
  assign odata_sample_4  = slot_q[4];
  assign odata_sample_5  = slot_q[5];
  assign odata_sample_6  = slot_q[6];
  assign odata_sample_7  = slot_q[7];
  assign odata_sample_8  = slot_q[8];
  assign odata_sample_9  = slot_q[9];
  assign odata_sample_10 = slot_q[10];
  assign odata_sample_11 = slot_q[11];
  assign odata_sample_12 = slot_q[12];
  assign odata_sample_13 = slot_q[13];
  assign odata_sample_14 = slot_q[14];
  assign odata_sample_15 = slot_q[15];
  assign odata_sample_16 = slot_q[16];
  assign odata_sample_17 = slot_q[17];
  assign odata_sample_18 = slot_q[18];
  assign odata_sample_19 = slot_q[19];

endmodule

// File: doc/rx_sample_window_buffer.md
Name: rx_sample_window_buffer

Overview:
- Circular 20-entry sample store that feeds rx_correlation_unit.
- Accepts one filtered signed sample per valid strobe from the rx filter stage.
- Holds the most recent 20 samples in place (no shifting) and presents all 20 in parallel, plus an order pointer and a one-cycle new-sample trigger.
- The correlator uses the order pointer to align its code chips to the oldest stored sample.

Parameters:
- SAMPLE_W, 16, width of the signed sample; must match the correlator input width.
- DEPTH, 20, number of stored samples; fixed by the correlator port count; other values are unsupported.
- DECIM, 4, decimation factor, used only when RX_SWB_DECIM_EN is defined; legal range 1..15.

Ports:
- crx_clk  in  1  clock
- rrx_rst  in  1  reset, asynchronous, active-high
- erx_en  in  1  block enable; low freezes all state
- idata_in  in  SAMPLE_W  signed input sample from rx filter
- idata_valid  in  1  qualifies idata_in for one cycle
- iflush  in  1  synchronous clear of contents and counters
- odata_sample_0 .. odata_sample_19  out  SAMPLE_W each  storage slots 0..19, registered
- oorder_pointer  out  5  slot index of the oldest sample, 0..19
- onew_sample_trig  out  1  one-cycle pulse: window updated and full
- ofill_level  out  5  number of valid samples stored, 0..20
- oprimed  out  1  high once 20 samples are stored

Behaviour:
- Reset (async, rrx_rst=1): all slots 0, write pointer 0, oorder_pointer 0, ofill_level 0, oprimed 0, onew_sample_trig 0, decimation counter 0.
- Accept condition: erx_en=1 AND idata_valid=1 (AND decimation phase==0 when the optional feature is compiled in).
- On accept: slot[wr_ptr] <= idata_in.
  - wr_ptr <= (wr_ptr==19) ? 0 : wr_ptr+1; no value outside 0..19 ever occurs.
  - ofill_level increments, saturating at 20.
  - oprimed sets when ofill_level reaches 20 and stays set until reset or flush.
- oorder_pointer always equals wr_ptr, the next slot to overwrite and the oldest sample once primed. It updates in the same edge as the slot write.
- onew_sample_trig:
  - Registered; asserted for exactly one cycle, in the cycle after an accept whose write leaves the buffer full. The first pulse follows the 20th accepted sample.
  - At that point the outputs already show the new slot contents and the new oorder_pointer, so data, pointer and trigger are coherent in the same cycle.
  - Latency from accepted sample to trig = 1 clock.
- Back-to-back valids (every cycle) are accepted every cycle; trig pulses every cycle once primed. No backpressure and no overflow condition: oldest data is overwritten.
- erx_en=0: no writes, no counter changes, onew_sample_trig forced 0; outputs hold their values.
- iflush=1 (requires erx_en=1): next edge clears slots, wr_ptr, fill, primed and decimation counter. Flush wins over a simultaneous valid; that sample is discarded and trig is 0.
- Reset asserted mid-operation clears immediately. The first accept after release writes slot 0.
- Arithmetic: data is stored verbatim with no scaling or sign change. Pointer and fill counters are 5-bit unsigned.

Optional Feature:
- Macro RX_SWB_DECIM_EN.
- Defined:
  - A 4-bit phase counter advances on each erx_en&idata_valid and wraps at DECIM-1.
  - Only samples arriving at phase 0 are accepted.
  - Flush and reset zero the phase.
  - Trig rate = valid rate / DECIM.
- Undefined: the counter logic is absent, DECIM is ignored, and every valid sample is accepted.

Test Plan:
- Reset then 19 valid samples 1..19 -> ofill_level=19, oprimed=0, no trig; slot k holds k+1; oorder_pointer=19.
- 20th sample value 20 -> next cycle trig=1 for one cycle, oprimed=1, oorder_pointer=0, slot19=20.
- 25 samples total, values 1..25, continuous valid -> slots0..4 = 21..25, slots5..19 = 6..20, oorder_pointer=5; trig on 6 consecutive cycles.
- Samples -32768 and 32767 -> stored bit-exact; erx_en=0 with valid for 5 cycles -> no change, trig 0.
- iflush with valid in same cycle after priming -> fill 0, primed 0, pointer 0, all slots 0, no trig; async reset asserted mid-burst -> outputs 0 without waiting for a clock edge.
- With RX_SWB_DECIM_EN, DECIM=4, 80 consecutive valid samples 0..79 -> slots hold 0,4,...,76, first trig after sample 76, oorder_pointer=0.
